// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter
// Shares the peripheral block's single req/gnt/rvalid data port between two
// masters (m0 = CPU data port, m1 = DMA/debug). Grants and responses pass
// through combinationally; an in-order FIFO of granted master IDs steers each
// response back to the master that issued it.
//
// Build option: define PERIPH_ARB_ROUND_ROBIN_EN to resolve simultaneous
// requests round-robin (the opposite of the most recent grant). When it is
// left undefined, ties always go to master 0 and no last-grant register exists.
//
// Handshake semantics (request side): a request is issued while s_req is high
// and is accepted on the cycle where s_req & s_gnt. A request that saw s_req
// without s_gnt is locked: the same master stays selected, and must keep its
// address-phase fields stable, until it is accepted. Response side: every
// s_rvalid while transactions are outstanding completes the oldest one;
// s_rvalid with nothing outstanding is ignored.
module periph_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (CPU data port)
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  // master 1 (DMA / debug)
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  // peripheral block slave port
  output logic        s_req,
  output logic        s_we,
  output logic [3:0]  s_be,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_gnt,
  input  logic        s_rvalid,
  input  logic        s_err,
  input  logic [31:0] s_rdata
);

  // Pointer width is at least one bit so a depth-1 FIFO still has a pointer.
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Arbitration state
  logic                       r_lock_valid;
  logic                       r_lock_id;

  // Outstanding-transaction ID FIFO
  logic [MAX_OUTSTANDING-1:0] r_fifo;
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [CNT_W-1:0]           r_count;

  // Combinational nets
  logic                       w_tie_id;
  logic                       w_sel_valid;
  logic                       w_sel_id;
  logic                       w_full;
  logic                       w_s_req;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_head_id;

  // Advance a FIFO pointer, wrapping at the configured depth (which need not
  // be a power of two).
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

`ifdef PERIPH_ARB_ROUND_ROBIN_EN
  logic r_last_id;

  // Ties go to whichever master was not granted most recently.
  assign w_tie_id = ~r_last_id;

  // Remember the most recently granted master; reset makes m0 win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_id <= 1'b1;
    end else if (w_push) begin
      r_last_id <= w_sel_id;
    end
  end
`else
  // Fixed priority: master 0 wins every tie.
  assign w_tie_id = 1'b0;
`endif

  // Pick the master to present to the peripheral this cycle.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_id    = 1'b0;
    if (r_lock_valid) begin
      w_sel_valid = 1'b1;
      w_sel_id    = r_lock_id;
    end else if (m0_req && m1_req) begin
      w_sel_valid = 1'b1;
      w_sel_id    = w_tie_id;
    end else if (m0_req || m1_req) begin
      w_sel_valid = 1'b1;
      w_sel_id    = m1_req;
    end
  end

  // No new request may be issued once every FIFO slot is taken; a response
  // arriving in the same cycle frees a slot only from the next cycle on.
  assign w_full  = (r_count == CNT_MAX);
  assign w_s_req = w_sel_valid & ~w_full;

  assign w_push    = w_s_req & s_gnt;
  assign w_pop     = s_rvalid & (r_count != '0);
  assign w_head_id = r_fifo[r_rd_ptr];

  // Forward the selected master's address phase; idle fields read as zero.
  always_comb begin
    s_req   = 1'b0;
    s_we    = 1'b0;
    s_be    = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (w_s_req) begin
      s_req = 1'b1;
      if (w_sel_id) begin
        s_we    = m1_we;
        s_be    = m1_be;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
      end else begin
        s_we    = m0_we;
        s_be    = m0_be;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
      end
    end
  end

  // Route the peripheral grant to the selected master only.
  always_comb begin
    m0_gnt = w_push & ~w_sel_id;
    m1_gnt = w_push &  w_sel_id;
  end

  // Steer the response to the master at the FIFO head; read data is shared
  // and each master qualifies it with its own rvalid.
  always_comb begin
    m0_rvalid = w_pop & ~w_head_id;
    m1_rvalid = w_pop &  w_head_id;
    m0_err    = w_pop & ~w_head_id & s_err;
    m1_err    = w_pop &  w_head_id & s_err;
    m0_rdata  = s_rdata;
    m1_rdata  = s_rdata;
  end

  // Hold the selection while the peripheral stalls an issued request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_valid <= 1'b0;
      r_lock_id    <= 1'b0;
    end else if (w_s_req && !s_gnt) begin
      r_lock_valid <= 1'b1;
      r_lock_id    <= w_sel_id;
    end else if (w_push) begin
      r_lock_valid <= 1'b0;
    end
  end

  // Record each accepted request's master ID in issue order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo   <= '0;
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_fifo[r_wr_ptr] <= w_sel_id;
      r_wr_ptr         <= ptr_next(r_wr_ptr);
    end
  end

  // Retire the oldest ID on each response that has a matching request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= ptr_next(r_rd_ptr);
    end
  end

  // Track the number of outstanding transactions; push+pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/periph_bus_arbiter.md
# periph_bus_arbiter

Two-master arbiter sharing the single data port of the peripheral block (GPIO, RAM, timer32, interrupt controller, UART) between the CPU data port (master 0) and a second bus master such as a DMA or debug module (master 1). It presents one req/gnt/rvalid slave port to the peripheral block. An in-order FIFO of granted master IDs steers each response back to its issuer. The arbiter adds no latency: grants and responses pass through combinationally.

## Interface
- `MAX_OUTSTANDING`, default 2: maximum granted transactions awaiting rvalid (ID FIFO depth, range 1–4).
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `m0_req`, `m0_we` in 1 each; `m0_be` in 4; `m0_addr`, `m0_wdata` in 32 each: master 0 request channel.
- `m0_gnt`, `m0_rvalid`, `m0_err` out 1 each; `m0_rdata` out 32: master 0 grant and response.
- `m1_*`: same set as `m0_*` for master 1.
- `s_req`, `s_we` out 1 each; `s_be` out 4; `s_addr`, `s_wdata` out 32 each: request to the peripheral block.
- `s_gnt`, `s_rvalid`, `s_err` in 1 each; `s_rdata` in 32: peripheral block grant and response.

## Operation
- State:
  - `lock_valid` and `lock_id`: a pending, ungranted selection.
  - `last_id`: the master granted most recently.
  - ID FIFO: `MAX_OUTSTANDING` entries of 1 bit, with `count`, a write pointer and a read pointer.
- Selection is combinational:
  - If `lock_valid`, select `lock_id`.
  - Else if exactly one master requests, select it.
  - Else if both request, select `~last_id`.
  - Else select nothing.
- Full gating: when `count == MAX_OUTSTANDING`, `s_req=0` and both `m*_gnt=0`, even if `s_rvalid` is high in the same cycle.
- Forwarding: `s_req/we/be/addr/wdata` follow the selected master. With nothing selected or FIFO full, `s_req=0` and all other `s_*` outputs are 0.
- Grant routing: `m<sel>_gnt = s_gnt & s_req`. The unselected master's gnt is 0.
- Lock:
  - Set when `s_req & ~s_gnt`, with `lock_id` = the selected master.
  - Cleared on `s_req & s_gnt`.
  - The locked master's address-phase fields must stay stable until granted; the arbiter does not check this.
- Grant handshake (`s_req & s_gnt`): push the selected ID into the FIFO and set `last_id` to that ID.
- Response:
  - On `s_rvalid` with `count>0`, pop the head ID.
  - Drive `m<head>_rvalid=1` and `m<head>_err=s_err`.
  - `s_rdata` is broadcast to both `m*_rdata`. Masters qualify it with their own rvalid.
- Spurious `s_rvalid` with `count==0`: dropped. No `m*_rvalid`, no state change.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. Pointers wrap modulo `MAX_OUTSTANDING`.
- `count` is ($clog2(MAX_OUTSTANDING)+1) bits wide and never exceeds `MAX_OUTSTANDING`.

## Timing
- Reset values:
  - `count=0`, both pointers 0, `lock_valid=0`, `last_id=1` (master 0 wins the first tie).
  - Outputs: all `m*_gnt`, `m*_rvalid`, `m*_err` are 0. `s_req=0` until a request arrives after reset deasserts.
- Grant path: `m*_req` → `s_req`, and `s_gnt` → `m*_gnt`, are combinational in the same cycle (0 added cycles).
- Response path: `s_rvalid` → `m*_rvalid` is combinational from the FIFO head (0 added cycles). The peripheral block's own latency (rvalid one cycle after gnt) is preserved.
- Back-to-back: a master may be granted every cycle while `count<MAX_OUTSTANDING`.
- Reset mid-operation: FIFO and lock are cleared. Responses for transactions granted before reset are dropped as spurious.

## Configuration
- Macro `PERIPH_ARB_ROUND_ROBIN_EN`.
- Defined: ties go to `~last_id` (round-robin), as described above.
- Undefined: ties always go to master 0 (fixed priority). `last_id` is not implemented. Lock and FIFO behaviour are identical in both modes.

## Test plan
- **Single master read.** After reset, m0 reads addr 0x0000_1000; peripheral gnt the same cycle, rvalid next cycle with rdata 0xDEAD_BEEF.
  - Required: m0_gnt in cycle 0; m0_rvalid=1 and m0_rdata=0xDEAD_BEEF in cycle 1; m1_rvalid=0 throughout.
- **Simultaneous requests, 4 cycles, always granted.**
  - Round-robin build: grant order m0, m1, m0, m1.
  - Fixed-priority build: m0 every cycle and m1 never granted.
- **Stall and lock.** m1 alone requests with s_gnt held low 3 cycles; m0 raises req in cycle 1.
  - Required: s_addr stays m1's address for all 3 cycles; m1 is granted in cycle 3; m0 is granted in cycle 4.
- **FIFO full**, MAX_OUTSTANDING=2. Grant 2 transactions with rvalid withheld.
  - Required: s_req=0 while full, including the cycle where rvalid arrives.
  - Required: the next grant occurs the cycle after the first rvalid, and responses return to m0 then m1 in grant order.
- **Error and spurious response.**
  - With count=0, pulse s_rvalid: no m*_rvalid.
  - m1 transaction returning s_err=1: m1_err=1 with m1_rvalid; m0_err=0.
- **Reset mid-operation.** Assert rst for 1 cycle with 2 transactions outstanding, then deliver 2 rvalids.
  - Required: both rvalids are dropped, and a following m0 request is granted normally.
